frame_pingpong_ctrl: RTL and testbench

Ping-pong scheduler for the packet BRAM written by the frame assembler. It steers the assembler's word writes into one of two 32 KiB banks and swaps banks on each frame-complete trigger. It then offers the finished bank to the downstream reader (Ethernet/UART sender) through a request/ack/done handshake. If the reader still holds the other bank, the frame is dropped and counted, so the assembler never stalls.

---
 rtl/frame_pp_pkg.sv | 27 ++
 rtl/frame_pingpong_ctrl_if.sv | 41 ++++
 rtl/rise_detect.sv | 29 ++
 rtl/frame_pingpong_ctrl.sv | 150 +++++++++++++++
 tb/tb_frame_pingpong_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_pp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : frame_pp_pkg
//  Purpose  : Shared types and widths for the packet-BRAM ping-pong scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package frame_pp_pkg;

    localparam int LEN_W  = 16;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2,
        READING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_OFFER = 2'd1,
        R_BUSY  = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/frame_pingpong_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : frame_pingpong_ctrl_if
//  Purpose  : Producer, BRAM-write and reader handshake bundle for the
//             ping-pong scheduler; master = producer/reader side.
//  Revision : 1.0  initial release
// ============================================================================
interface frame_pingpong_ctrl_if
    import frame_pp_pkg::*;
#(
    parameter int DROP_W = 8
);
    logic              wr_start;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;
    logic              bram_we;
    logic [ADDR_W:0]   bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              rd_req;
    logic              rd_bank;
    logic [LEN_W-1:0]  rd_len;
    logic              rd_ack;
    logic              rd_done;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output wr_start, wr_addr, wr_data, frame_done, rd_ack, rd_done,
        input  bram_we, bram_addr, bram_din, rd_req, rd_bank, rd_len,
               overflow, drop_cnt
    );

    modport slave (
        input  wr_start, wr_addr, wr_data, frame_done, rd_ack, rd_done,
        output bram_we, bram_addr, bram_din, rd_req, rd_bank, rd_len,
               overflow, drop_cnt
    );

endinterface
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// ============================================================================
//  Module   : rise_detect
//  Purpose  : Registered rising-edge detector; one-cycle pulse per 0->1.
//  Revision : 1.0  initial release
// ============================================================================
module rise_detect (
    input  wire logic aclk,
    input  wire logic rst,
    input  wire logic i_din,
    output logic      o_rise
);
    logic r_prev;
    logic r_rise;

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_prev <= i_din;
            r_rise <= i_din & ~r_prev;
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/frame_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : frame_pingpong_ctrl
//  Purpose  : Two-bank ping-pong scheduler: steers producer writes, swaps on
//             frame completion, offers finished banks to the reader.
//  Revision : 1.0  initial release
// ============================================================================
module frame_pingpong_ctrl
    import frame_pp_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input wire logic             aclk,
    input wire logic             rst,
    frame_pingpong_ctrl_if.slave bus
);
    localparam logic [LEN_W-1:0] c_WORD_BYTES = LEN_W'(4);

    bank_state_t [1:0] r_bank_st,   w_bank_st;
    rd_state_t         r_rd_state,  w_rd_state;
    logic              r_wr_bank,   w_wr_bank;
    logic [ADDR_W-1:0] r_max_addr,  w_max_addr;
    logic              r_any_wr,    w_any_wr;
    logic [LEN_W-1:0]  r_ready_len, w_ready_len;
    logic              r_rd_bank,   w_rd_bank;
    logic [LEN_W-1:0]  r_rd_len,    w_rd_len;
    logic [DROP_W-1:0] r_drop_cnt,  w_drop_cnt;
    logic              r_overflow,  w_drop;
    logic              r_bram_we;
    logic [ADDR_W:0]   r_bram_addr;
    logic [DATA_W-1:0] r_bram_din;
    logic              w_fd_rise;
    logic              w_other;

    rise_detect u_fd_rise (
        .aclk   (aclk),
        .rst    (rst),
        .i_din  (bus.frame_done),
        .o_rise (w_fd_rise)
    );

    assign w_other = ~r_wr_bank;

    // Reader transitions are resolved first so a same-cycle release lets the swap succeed.
    always_comb begin
        w_bank_st   = r_bank_st;
        w_rd_state  = r_rd_state;
        w_rd_bank   = r_rd_bank;
        w_rd_len    = r_rd_len;
        w_wr_bank   = r_wr_bank;
        w_max_addr  = r_max_addr;
        w_any_wr    = r_any_wr;
        w_ready_len = r_ready_len;
        w_drop_cnt  = r_drop_cnt;
        w_drop      = 1'b0;

        case (r_rd_state)
            R_IDLE: begin
                if (r_bank_st[w_other] == READY) begin
                    w_rd_bank  = w_other;
                    w_rd_len   = r_ready_len;
                    w_rd_state = R_OFFER;
                end
            end
            R_OFFER: begin
                if (bus.rd_ack) begin
                    w_bank_st[r_rd_bank] = READING;
                    w_rd_state           = R_BUSY;
                end
            end
            R_BUSY: begin
                if (bus.rd_done) begin
                    w_bank_st[r_rd_bank] = FREE;
                    w_rd_state           = R_IDLE;
                end
            end
            default: w_rd_state = R_IDLE;
        endcase

        if (bus.wr_start) begin
            w_any_wr = 1'b1;
            if (bus.wr_addr > r_max_addr) begin
                w_max_addr = bus.wr_addr;
            end
        end

        // Empty frames are ignored entirely; otherwise swap or drop.
        if (w_fd_rise && w_any_wr) begin
            if (w_bank_st[w_other] == FREE) begin
                w_bank_st[r_wr_bank] = READY;
                w_bank_st[w_other]   = FILLING;
                w_ready_len          = LEN_W'(w_max_addr) + c_WORD_BYTES;
                w_wr_bank            = w_other;
            end else begin
                w_drop = 1'b1;
                if (r_drop_cnt != {DROP_W{1'b1}}) begin
                    w_drop_cnt = r_drop_cnt + 1'b1;
                end
            end
            w_max_addr = '0;
            w_any_wr   = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            r_bank_st[0] <= FILLING;
            r_bank_st[1] <= FREE;
            r_rd_state   <= R_IDLE;
            r_wr_bank    <= 1'b0;
            r_max_addr   <= '0;
            r_any_wr     <= 1'b0;
            r_ready_len  <= '0;
            r_rd_bank    <= 1'b0;
            r_rd_len     <= '0;
            r_drop_cnt   <= '0;
            r_overflow   <= 1'b0;
            r_bram_we    <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_din   <= '0;
        end else begin
            r_bank_st   <= w_bank_st;
            r_rd_state  <= w_rd_state;
            r_wr_bank   <= w_wr_bank;
            r_max_addr  <= w_max_addr;
            r_any_wr    <= w_any_wr;
            r_ready_len <= w_ready_len;
            r_rd_bank   <= w_rd_bank;
            r_rd_len    <= w_rd_len;
            r_drop_cnt  <= w_drop_cnt;
            r_overflow  <= w_drop;
            r_bram_we   <= bus.wr_start;
            if (bus.wr_start) begin
                r_bram_addr <= {r_wr_bank, bus.wr_addr};
                r_bram_din  <= bus.wr_data;
            end
        end
    end

    assign bus.bram_we   = r_bram_we;
    assign bus.bram_addr = r_bram_addr;
    assign bus.bram_din  = r_bram_din;
    assign bus.rd_req    = (r_rd_state == R_OFFER);
    assign bus.rd_bank   = r_rd_bank;
    assign bus.rd_len    = r_rd_len;
    assign bus.overflow  = r_overflow;
    assign bus.drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_pingpong_ctrl
//  Purpose  : Scoreboard bench for frame_pingpong_ctrl with an event-level
//             bank model and randomized producer/reader traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_frame_pingpong_ctrl;
    import frame_pp_pkg::*;

    localparam int c_DROP_W   = 3;
    localparam int c_DROP_MAX = (1 << c_DROP_W) - 1;
    localparam int c_M_FREE    = 0;
    localparam int c_M_READY   = 1;
    localparam int c_M_READING = 2;

    logic aclk = 1'b0;
    logic rst  = 1'b0;

    frame_pingpong_ctrl_if #(.DROP_W(c_DROP_W)) bus ();

    frame_pingpong_ctrl #(.DROP_W(c_DROP_W)) dut (
        .aclk (aclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic        bank;
        logic [15:0] len;
    } offer_t;

    wr_exp_t q_wr[$];
    offer_t  q_offer[$];
    int      q_ovf[$];

    int n_checks = 0;
    int n_errors = 0;

    // Abstract model: which bank the producer fills, what the other bank is doing.
    bit m_wr_bank;
    int m_other;
    int m_max;
    bit m_any;
    int m_drops;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, offer or drop.
    logic    r_prev_req = 1'b0;
    wr_exp_t r_mon_wr;
    offer_t  r_mon_off;
    int      r_mon_ovf;
    always @(negedge aclk) begin
        if (!rst) begin
            r_prev_req <= 1'b0;
        end else begin
            if (bus.bram_we) begin
                if (q_wr.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    r_mon_wr = q_wr.pop_front();
                    check("bram_addr", bus.bram_addr, r_mon_wr.addr);
                    check("bram_din", bus.bram_din, r_mon_wr.data);
                end
            end
            if (bus.rd_req && !r_prev_req) begin
                if (q_offer.size() == 0) begin
                    check("unexpected_offer", 1, 0);
                end else begin
                    r_mon_off = q_offer.pop_front();
                    check("rd_bank", bus.rd_bank, r_mon_off.bank);
                    check("rd_len", bus.rd_len, r_mon_off.len);
                end
            end
            if (bus.overflow) begin
                if (q_ovf.size() == 0) begin
                    check("unexpected_overflow", 1, 0);
                end else begin
                    r_mon_ovf = q_ovf.pop_front();
                    check("drop_cnt", bus.drop_cnt, r_mon_ovf);
                end
            end
            r_prev_req <= bus.rd_req;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic model_reset();
        m_wr_bank = 1'b0;
        m_other   = c_M_FREE;
        m_max     = 0;
        m_any     = 1'b0;
        m_drops   = 0;
    endtask

    task automatic model_write(input logic [14:0] addr, input logic [31:0] data);
        q_wr.push_back(wr_exp_t'({m_wr_bank, addr, data}));
        m_any = 1'b1;
        if (int'(addr) > m_max) m_max = int'(addr);
    endtask

    task automatic model_frame();
        if (!m_any) return;
        if (m_other == c_M_FREE) begin
            q_offer.push_back(offer_t'({m_wr_bank, 16'(m_max + 4)}));
            m_other   = c_M_READY;
            m_wr_bank = ~m_wr_bank;
        end else begin
            if (m_drops < c_DROP_MAX) m_drops++;
            q_ovf.push_back(m_drops);
        end
        m_max = 0;
        m_any = 1'b0;
    endtask

    task automatic do_write(input logic [14:0] addr, input logic [31:0] data, input int hold);
        bus.wr_start = 1'b1;
        bus.wr_addr  = addr;
        bus.wr_data  = data;
        for (int i = 0; i < hold; i++) begin
            model_write(addr, data);
            tick();
        end
        bus.wr_start = 1'b0;
    endtask

    task automatic do_random_writes();
        int n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) begin
            do_write(15'($urandom_range(0, 32767)), $urandom, $urandom_range(1, 3));
        end
    endtask

    // kind: 0 plain, 1 rd_done with fd_rise, 2 rd_ack with fd_rise, 3 write with fd_rise.
    task automatic do_frame(input int kind, input logic [14:0] addr, input logic [31:0] data);
        bus.frame_done = 1'b1;
        tick();
        case (kind)
            1: begin bus.rd_done = 1'b1; m_other = c_M_FREE; end
            2: begin bus.rd_ack = 1'b1;  m_other = c_M_READING; end
            3: begin
                bus.wr_start = 1'b1;
                bus.wr_addr  = addr;
                bus.wr_data  = data;
                model_write(addr, data);
            end
            default: ;
        endcase
        model_frame();
        tick();
        bus.rd_done  = 1'b0;
        bus.rd_ack   = 1'b0;
        bus.wr_start = 1'b0;
        if (kind == 2) check("rd_req_drop_after_ack_fd", bus.rd_req, 0);
        repeat ($urandom_range(1, 4)) tick();
        bus.frame_done = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_ack();
        int t = 0;
        while (!bus.rd_req && t < 20) begin
            tick();
            t++;
        end
        check("rd_req_offer_present", bus.rd_req, 1);
        if (bus.rd_req) begin
            bus.rd_ack = 1'b1;
            tick();
            bus.rd_ack = 1'b0;
            check("rd_req_drop_after_ack", bus.rd_req, 0);
            m_other = c_M_READING;
        end
    endtask

    task automatic do_done();
        bus.rd_done = 1'b1;
        tick();
        bus.rd_done = 1'b0;
        m_other = c_M_FREE;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_bram_we"},   bus.bram_we,   0);
        check({tag, "_bram_addr"}, bus.bram_addr, 0);
        check({tag, "_bram_din"},  bus.bram_din,  0);
        check({tag, "_rd_req"},    bus.rd_req,    0);
        check({tag, "_rd_bank"},   bus.rd_bank,   0);
        check({tag, "_rd_len"},    bus.rd_len,    0);
        check({tag, "_overflow"},  bus.overflow,  0);
        check({tag, "_drop_cnt"},  bus.drop_cnt,  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int op;
        bus.wr_start   = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.frame_done = 1'b0;
        bus.rd_ack     = 1'b0;
        bus.rd_done    = 1'b0;
        model_reset();
        repeat (3) tick();
        chk_zero("reset");
        rst = 1'b1;
        tick();

        // Frame 1: 12 words held 4 cycles each -> bank0, len 48.
        for (int i = 0; i < 12; i++) do_write(15'(i * 4), 32'hA000_0000 + i, 4);
        do_frame(0, '0, '0);
        do_ack();

        // Frame 2 into bank1 up to 0x10; release bank0 first -> offer bank1, len 20.
        for (int i = 0; i <= 4; i++) do_write(15'(i * 4), 32'hB000_0000 + i, 1);
        do_done();
        do_frame(0, '0, '0);
        do_write(15'h0008, 32'hC0DE_0001, 2);

        // Reader busy on bank1: drop; then fill bank0 -> READY; then drop against READY.
        do_ack();
        do_frame(0, '0, '0);
        do_done();
        do_write(15'h0040, 32'h1111_2222, 1);
        do_frame(0, '0, '0);
        do_write(15'h0004, 32'h3333_4444, 2);
        do_frame(0, '0, '0);

        // Empty frame: nothing changes.
        do_frame(0, '0, '0);
        check("drop_cnt_empty_frame", bus.drop_cnt, m_drops);
        check("rd_req_empty_frame", bus.rd_req, 1);

        // rd_done coincident with fd_rise: swap must succeed.
        do_ack();
        do_write(15'h0100, 32'h5555_6666, 1);
        do_frame(1, '0, '0);

        // rd_ack coincident with fd_rise: bank goes READING and frame drops.
        do_write(15'h0020, 32'h7777_8888, 1);
        do_frame(2, '0, '0);

        // Write coincident with fd_rise at the top address -> len 32768.
        do_done();
        do_write(15'h0100, 32'h9999_AAAA, 1);
        do_frame(3, 15'h7FFC, 32'hDEAD_BEEF);

        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                do_random_writes();
            end else if (op <= 6) begin
                if ($urandom_range(0, 1) == 1)
                    do_frame(3, 15'($urandom_range(0, 32767)), $urandom);
                else
                    do_frame(0, '0, '0);
            end else if (op == 7) begin
                if (m_other == c_M_READY) do_ack();
            end else if (op == 8) begin
                if (m_other == c_M_READING) do_done();
            end else begin
                if (m_other == c_M_READING)    do_frame(1, '0, '0);
                else if (m_other == c_M_READY) do_frame(2, '0, '0);
                else                           do_frame(0, '0, '0);
            end
        end
        check("drop_cnt_after_random", bus.drop_cnt, m_drops);

        // Reset while an offer is outstanding.
        if (m_other == c_M_READING) do_done();
        if (m_other == c_M_FREE) begin
            do_write(15'h0010, 32'h0F0F_0F0F, 1);
            do_frame(0, '0, '0);
        end
        check("rd_req_before_reset", bus.rd_req, 1);
        @(negedge aclk);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("rst_offer");
        tick();
        rst = 1'b1;
        model_reset();
        tick();

        // Reset during a write burst.
        bus.wr_start = 1'b1;
        bus.wr_addr  = 15'h0044;
        bus.wr_data  = 32'h2468_ACE0;
        model_write(15'h0044, 32'h2468_ACE0);
        model_write(15'h0044, 32'h2468_ACE0);
        tick();
        tick();
        @(negedge aclk);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("rst_write");
        bus.wr_start = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        tick();

        do_write(15'h0123, 32'h1357_9BDF, 1);
        check("post_reset_bank", bus.bram_addr[15], 0);
        do_frame(0, '0, '0);
        do_ack();
        do_done();

        repeat (5) tick();
        check("writes_drained", q_wr.size(), 0);
        check("offers_drained", q_offer.size(), 0);
        check("overflows_drained", q_ovf.size(), 0);
        check("drop_cnt_final", bus.drop_cnt, m_drops);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
